trig_chain_checker: RTL and testbench

- Consumes the per-stage trigger pulses of an N-stage event/trigger chain, one pulse per stage, where stage i fires stage i+1.
- Verifies that stages fire strictly in order and that the gap between consecutive stages never exceeds a cycle budget.
- Keeps a sticky "triggered" bit per stage and reports done/error to the test harness.
- Sits directly downstream of the chain, as its completion and ordering monitor.

---
 rtl/trig_chain_checker.sv | 93 +++++++++
 tb/tb_trig_chain_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/trig_chain_checker.sv
// trig_chain_checker: in-order completion and gap-timeout monitor for an N-stage trigger chain.
// Define TRIG_CHAIN_MULTI_EN to accept contiguous same-cycle bursts of stage triggers.
module trig_chain_checker #(
  parameter int N = 100,
  parameter int TIMEOUT = 16,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  trig,
  output logic [N-1:0]  triggered,
  output logic [IW-1:0] next_idx,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code
);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);
  localparam logic [N-1:0] ONE = N'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;
  state_t state;
  logic [GW-1:0] gap;
  logic [N-1:0] expect_bit;
  logic accept;
  logic [IW-1:0] hi_idx;
  assign expect_bit = ONE << next_idx;
`ifdef TRIG_CHAIN_MULTI_EN
  logic [N-1:0] upper;
  // legal burst: nothing below k, and the bits from k upward form a solid run of ones
  always_comb begin
    upper = trig >> next_idx;
    accept = (upper != '0) && ((upper & (upper + ONE)) == '0) && ((trig & (expect_bit - ONE)) == '0);
    hi_idx = next_idx;
    for (int i = 0; i < N; i++) hi_idx = trig[i] ? IW'(i) : hi_idx;
  end
`else
  assign accept = trig == expect_bit;
  assign hi_idx = next_idx;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      triggered <= '0;
      next_idx <= '0;
      gap <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= 2'd0;
    end else if (start && state != RUN) begin
      state <= RUN;
      triggered <= '0;
      next_idx <= '0;
      gap <= '0;
      busy <= 1'b1;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= 2'd0;
    end else if (state == IDLE && trig != '0) begin
      state <= FAIL;
      error <= 1'b1;
      err_code <= 2'd3;
    end else if (state == RUN) begin
      if (trig == '0) begin
        gap <= (gap == GAP_LAST) ? gap : gap + GW'(1);
        if (gap == GAP_LAST) begin
          state <= FAIL;
          busy <= 1'b0;
          error <= 1'b1;
          err_code <= 2'd2;
        end
      end else if (accept) begin
        triggered <= triggered | trig;
        gap <= '0;
        if (trig[N-1]) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          next_idx <= IW'(N - 1);
        end else begin
          next_idx <= hi_idx + IW'(1);
        end
      end else begin
        state <= FAIL;
        busy <= 1'b0;
        error <= 1'b1;
        err_code <= 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_trig_chain_checker.sv
// tb_trig_chain_checker: vector table, directed corner sequences and random traffic vs. a set-based model.
module tb_trig_chain_checker;
  localparam int N = 100;
  localparam int TIMEOUT = 16;
  localparam int IW = $clog2(N);
  logic clk = 1'b0;
  logic rst, start;
  logic [N-1:0] trig;
  logic [N-1:0] triggered;
  logic [IW-1:0] next_idx;
  logic busy, done, error;
  logic [1:0] err_code;
  int checks = 0;
  int errors = 0;
  int st;
  logic [N-1:0] m_trig;
  int m_idx, m_gap, m_code;
  bit m_done, m_err;
  trig_chain_checker #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .trig(trig), .triggered(triggered),
    .next_idx(next_idx), .busy(busy), .done(done), .error(error), .err_code(err_code)
  );
  always #5 clk = ~clk;
  typedef struct {
    bit r;
    bit s;
    logic [N-1:0] t;
    bit busy;
    bit err;
    logic [1:0] code;
    int idx;
  } vec_t;
  vec_t tbl[11];
  function automatic logic [N-1:0] bit_of(int i);
    bit_of = '0;
    bit_of[i] = 1'b1;
  endfunction
  function automatic logic [N-1:0] span(int lo, int hi);
    span = '0;
    for (int i = lo; i <= hi; i++) span[i] = 1'b1;
  endfunction
  function automatic vec_t v(bit r, bit s, logic [N-1:0] t, bit b, bit e, logic [1:0] c, int i);
    v.r = r; v.s = s; v.t = t; v.busy = b; v.err = e; v.code = c; v.idx = i;
  endfunction
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic arm();
    st = 1; m_trig = '0; m_idx = 0; m_gap = 0; m_done = 0; m_err = 0; m_code = 0;
  endtask
  task automatic fail_with(int c);
    st = 3; m_err = 1; m_code = c;
  endtask
  // model: a trigger word is legal when its set bits form one run starting exactly at the expected stage
  task automatic model(bit r, bit s, logic [N-1:0] t);
    int lo, hi, cnt;
    bit ok;
    if (r) begin
      st = 0; m_trig = '0; m_idx = 0; m_gap = 0; m_done = 0; m_err = 0; m_code = 0;
    end else if (st == 0) begin
      if (s) arm();
      else if (t != '0) fail_with(3);
    end else if (st == 1) begin
      if (t == '0) begin
        m_gap++;
        if (m_gap >= TIMEOUT) fail_with(2);
      end else begin
        lo = -1; hi = -1; cnt = 0;
        for (int i = 0; i < N; i++) if (t[i]) begin
          if (lo < 0) lo = i;
          hi = i;
          cnt++;
        end
        ok = (lo == m_idx) && (cnt == hi - lo + 1);
`ifndef TRIG_CHAIN_MULTI_EN
        ok = ok && (cnt == 1);
`endif
        if (!ok) fail_with(1);
        else begin
          for (int i = lo; i <= hi; i++) m_trig[i] = 1'b1;
          m_gap = 0;
          if (hi == N - 1) begin
            st = 2; m_done = 1; m_idx = N - 1;
          end else m_idx = hi + 1;
        end
      end
    end else if (s) arm();
  endtask
  task automatic step(bit r, bit s, logic [N-1:0] t);
    rst = r; start = s; trig = t;
    @(posedge clk);
    #1;
    model(r, s, t);
    rst = 1'b0; start = 1'b0; trig = '0;
    chk("triggered", 128'(triggered), 128'(m_trig));
    chk("next_idx", 128'(next_idx), 128'(m_idx));
    chk("busy", 128'(busy), 128'(st == 1));
    chk("done", 128'(done), 128'(m_done));
    chk("error", 128'(error), 128'(m_err));
    chk("err_code", 128'(err_code), 128'(m_code));
  endtask
  task automatic full_run();
    step(0, 1, '0);
    for (int i = 0; i < N; i++) step(0, 0, bit_of(i));
  endtask
  initial begin
    logic [N-1:0] t;
    int p, len;
    bit s;
    rst = 1'b1; start = 1'b0; trig = '0;
    st = 0; m_trig = '0; m_idx = 0; m_gap = 0; m_code = 0; m_done = 0; m_err = 0;
    tbl[0]  = v(1, 0, '0, 0, 0, 0, 0);
    tbl[1]  = v(0, 0, bit_of(0), 0, 1, 3, 0);
    tbl[2]  = v(0, 1, '0, 1, 0, 0, 0);
    tbl[3]  = v(0, 0, bit_of(0), 1, 0, 0, 1);
    tbl[4]  = v(0, 0, bit_of(1), 1, 0, 0, 2);
    tbl[5]  = v(0, 0, bit_of(1), 0, 1, 1, 2);
    tbl[6]  = v(0, 0, bit_of(5), 0, 1, 1, 2);
    tbl[7]  = v(0, 1, bit_of(0), 1, 0, 0, 0);
    tbl[8]  = v(0, 0, '0, 1, 0, 0, 0);
    tbl[9]  = v(0, 1, bit_of(0), 1, 0, 0, 1);
    tbl[10] = v(0, 0, bit_of(2), 0, 1, 1, 1);
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].s, tbl[i].t);
      chk("tbl_busy", 128'(busy), 128'(tbl[i].busy));
      chk("tbl_error", 128'(error), 128'(tbl[i].err));
      chk("tbl_code", 128'(err_code), 128'(tbl[i].code));
      chk("tbl_idx", 128'(next_idx), 128'(tbl[i].idx));
    end
    step(0, 1, '0);
    for (int i = 0; i < N - 1; i++) step(0, 0, bit_of(i));
    chk("run_not_done_early", 128'(done), 128'(0));
    step(0, 0, bit_of(N - 1));
    chk("run_done", 128'(done), 128'(1));
    chk("run_all_ones", 128'(triggered), 128'(span(0, N - 1)));
    chk("run_idx", 128'(next_idx), 128'(N - 1));
    chk("run_busy", 128'(busy), 128'(0));
    chk("run_error", 128'(error), 128'(0));
    step(0, 0, bit_of(3));
    chk("done_ignores_trig", 128'(error), 128'(0));
    step(0, 1, '0);
    for (int i = 0; i < 5; i++) step(0, 0, bit_of(i));
    step(0, 0, bit_of(6));
    chk("order_err", 128'(err_code), 128'(1));
    chk("order_trig", 128'(triggered), 128'(span(0, 4)));
    chk("order_idx", 128'(next_idx), 128'(5));
    step(0, 1, '0);
    step(0, 0, bit_of(0));
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, '0);
    chk("to_not_yet", 128'(error), 128'(0));
    step(0, 0, '0);
    chk("to_error", 128'(error), 128'(1));
    chk("to_code", 128'(err_code), 128'(2));
    step(0, 1, '0);
    step(0, 0, bit_of(0));
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, '0);
    step(0, 0, bit_of(1));
    chk("to15_ok", 128'(error), 128'(0));
    chk("to15_idx", 128'(next_idx), 128'(2));
    step(1, 0, '0);
    step(0, 0, bit_of(0));
    chk("idle_trig", 128'(err_code), 128'(3));
    full_run();
    chk("after_idle_done", 128'(done), 128'(1));
    step(0, 1, '0);
    for (int i = 0; i <= 50; i++) step(0, 0, bit_of(i));
    step(1, 0, '0);
    chk("rst_clear", {triggered, 7'(next_idx), busy, done, error, err_code}, 128'(0));
    full_run();
    chk("after_rst_done", 128'(done), 128'(1));
`ifdef TRIG_CHAIN_MULTI_EN
    step(0, 1, '0);
    step(0, 0, span(0, N - 1));
    chk("burst_done", 128'(done), 128'(1));
    step(0, 1, '0);
    step(0, 0, bit_of(0) | bit_of(1) | bit_of(3));
    chk("burst_hole", 128'(err_code), 128'(1));
    step(0, 1, '0);
    step(0, 0, span(0, 4));
    chk("burst_idx", 128'(next_idx), 128'(5));
    step(0, 0, span(4, 6));
    chk("burst_below", 128'(err_code), 128'(1));
`else
    step(0, 1, '0);
    step(0, 0, bit_of(0) | bit_of(1));
    chk("pair_rejected", 128'(err_code), 128'(1));
`endif
    for (int c = 0; c < 4000; c++) begin
      p = int'($urandom_range(0, 99));
      t = '0;
      if (p < 55) t = bit_of(m_idx);
      else if (p < 80) t = '0;
      else if (p < 90) t = bit_of(int'($urandom_range(0, N - 1)));
      else begin
        len = int'($urandom_range(1, 4));
        t = span(m_idx, (m_idx + len - 1 > N - 1) ? N - 1 : m_idx + len - 1);
        if ($urandom_range(0, 3) == 0 && m_idx + 2 < N) t[m_idx + 1] = 1'b0;
      end
      s = ($urandom_range(0, 99) < 3) || (st != 1 && $urandom_range(0, 99) < 30);
      step($urandom_range(0, 199) == 0, s, t);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
